// File: rtl/max_finder.sv
// Signed argmax over a captured vector of neuron outputs, one element per clock.
// Define MAX_FINDER_MAXVAL_EN to add the o_max port carrying the winning value.
module max_finder #(
    parameter int num_inputs = 10,
    parameter int data_width = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [num_inputs*data_width-1:0] i_data,
    input  logic [num_inputs-1:0]            i_valid,
    output logic [31:0]                      o_index,
    output logic                             o_valid,
    output logic                             o_busy
`ifdef MAX_FINDER_MAXVAL_EN
    ,
    output logic [data_width-1:0]            o_max
`endif
);

    localparam int CW = (num_inputs > 1) ? $clog2(num_inputs) : 1;
    localparam logic [CW-1:0] LAST = CW'(num_inputs - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                state;
    logic [data_width-1:0] buf_q [num_inputs];
    logic [data_width-1:0] max_reg;
    logic [CW-1:0]         idx_reg;
    logic [CW-1:0]         cnt;

    logic                  start;
    logic [data_width-1:0] first_elem;
    logic [data_width-1:0] elem;
    logic                  gt;
    logic [CW-1:0]         win_idx;
    logic [data_width-1:0] win_val;

    assign start      = &i_valid;
    assign first_elem = i_data[data_width-1:0];
    assign elem       = buf_q[cnt];

    // Strictly-greater keeps the earlier index on ties.
    assign gt      = $signed(elem) > $signed(max_reg);
    assign win_idx = gt ? cnt : idx_reg;
    assign win_val = gt ? elem : max_reg;

    // Snapshot the whole vector when a scan starts; frozen during SCAN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < num_inputs; k++) begin
                buf_q[k] <= '0;
            end
        end else if (state == IDLE && start) begin
            for (int k = 0; k < num_inputs; k++) begin
                buf_q[k] <= i_data[k*data_width +: data_width];
            end
        end
    end

    // Control FSM: capture in IDLE, one compare per edge in SCAN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            max_reg <= '0;
            idx_reg <= '0;
            cnt     <= '0;
            o_index <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
`ifdef MAX_FINDER_MAXVAL_EN
            o_max   <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        max_reg <= first_elem;
                        idx_reg <= '0;
                        if (num_inputs == 1) begin
                            // A single element is its own winner.
                            cnt     <= '0;
                            o_index <= '0;
                            o_valid <= 1'b1;
`ifdef MAX_FINDER_MAXVAL_EN
                            o_max   <= first_elem;
`endif
                        end else begin
                            cnt    <= CW'(1);
                            o_busy <= 1'b1;
                            state  <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    max_reg <= win_val;
                    idx_reg <= win_idx;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        o_index <= 32'(win_idx);
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
`ifdef MAX_FINDER_MAXVAL_EN
                        o_max   <= win_val;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_finder.sv
// Bench for max_finder: directed and random vectors against an argmax model.
// Build with MAX_FINDER_MAXVAL_EN to also check o_max.
module tb_max_finder;

    localparam int N = 10;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_valid;
    logic [31:0]    o_index;
    logic           o_valid;
    logic           o_busy;
`ifdef MAX_FINDER_MAXVAL_EN
    logic [W-1:0]   o_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    max_finder #(
        .num_inputs(N),
        .data_width(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_index (o_index),
        .o_valid (o_valid),
        .o_busy  (o_busy)
`ifdef MAX_FINDER_MAXVAL_EN
        ,
        .o_max   (o_max)
`endif
    );

    always #5 clk = ~clk;

    // Reference: first position holding the largest signed value.
    function automatic int ref_argmax(input int e[N]);
        int best = 0;
        for (int k = 1; k < N; k++) begin
            if (e[k] > e[best]) best = k;
        end
        return best;
    endfunction

    function automatic logic [W-1:0] ref_maxval(input int e[N]);
        return W'(e[ref_argmax(e)]);
    endfunction

    task automatic load(input int e[N]);
        for (int k = 0; k < N; k++) begin
            i_data[k*W +: W] = W'(e[k]);
        end
    endtask

    // Present e with all-valid for one edge; returns at the negedge after capture.
    task automatic start_scan(input int e[N]);
        @(negedge clk);
        load(e);
        i_valid = '1;
        @(negedge clk);
        i_valid = '0;
    endtask

    // Edges until o_valid is seen, or -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        i_valid = '0;
        i_data  = '0;
        #1;
        n_checks++;
        if ({o_index, o_valid, o_busy} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: index=%0d valid=%b busy=%b, need 0/0/0",
                     o_index, o_valid, o_busy);
        end
`ifdef MAX_FINDER_MAXVAL_EN
        n_checks++;
        if (o_max !== '0) begin
            n_fail++;
            $display("FAIL reset_max: got %h need 0", o_max);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full scan of e with latency, pulse width, result and hold checks.
    task automatic run_and_check(input string tag, input int e[N]);
        int lat;
        int exp_idx;
        exp_idx = ref_argmax(e);
        start_scan(e);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: got %b need 1", tag, o_busy);
        end
        wait_valid(lat);
        n_checks++;
        if (lat != N - 1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d need %0d", tag, lat, N - 1);
        end
        n_checks++;
        if (o_index !== 32'(exp_idx)) begin
            n_fail++;
            $display("FAIL %s_index: got %0d need %0d", tag, o_index, exp_idx);
        end
`ifdef MAX_FINDER_MAXVAL_EN
        n_checks++;
        if (o_max !== ref_maxval(e)) begin
            n_fail++;
            $display("FAIL %s_max: got %h need %h", tag, o_max, ref_maxval(e));
        end
`endif
        @(negedge clk);
        n_checks++;
        if ({o_valid, o_busy} !== 2'b00 || o_index !== 32'(exp_idx)) begin
            n_fail++;
            $display("FAIL %s_after: valid=%b busy=%b index=%0d need 0/0/%0d",
                     tag, o_valid, o_busy, o_index, exp_idx);
        end
    endtask

    task automatic test_fixed;
        int e[N] = '{5, 3, 9, 1, 0, 2, 8, 7, 6, 4};
        run_and_check("fixed", e);
        n_checks++;
        if (o_index !== 32'd2) begin
            n_fail++;
            $display("FAIL fixed_const: got %0d need 2", o_index);
        end
    endtask

    task automatic test_ties;
        int e[N];
        for (int k = 0; k < N; k++) e[k] = 'h100;
        e[9] = 'h101;
        run_and_check("tie_last", e);
        e[9] = 'h100;
        run_and_check("tie_equal", e);
    endtask

    task automatic test_signed;
        int e[N];
        for (int k = 0; k < N; k++) e[k] = -32768;
        e[4] = -1;
        run_and_check("signed", e);
    endtask

    task automatic test_partial;
        int e[N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        int lat;
        bit seen = 0;
        @(negedge clk);
        load(e);
        i_valid = 10'h1FF;
        repeat (5) begin
            @(negedge clk);
            if (o_busy || o_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL partial_start: activity seen=1 need 0");
        end
        i_valid = 10'h3FF;
        @(negedge clk);
        i_valid = '0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_then_full: busy=%b need 1", o_busy);
        end
        wait_valid(lat);
        n_checks++;
        if (lat != N - 1 || o_index !== 32'd9) begin
            n_fail++;
            $display("FAIL partial_result: lat=%0d index=%0d need %0d/9",
                     lat, o_index, N - 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int e[N];
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) begin
                if (t % 2 == 0) e[k] = int'($urandom_range(0, 65535)) - 32768;
                else            e[k] = int'($urandom_range(0, 3)) - 2;
            end
            run_and_check($sformatf("rand%0d", t), e);
        end
    endtask

    task automatic test_back_to_back;
        int a[N];
        int b[N];
        int lat;
        for (int k = 0; k < N; k++) begin
            a[k] = int'($urandom_range(0, 65535)) - 32768;
            b[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        start_scan(a);
        repeat (3) @(negedge clk);
        load(b);
        i_valid = '1;
        wait_valid(lat);
        n_checks++;
        if (lat != N - 4 || o_index !== 32'(ref_argmax(a))) begin
            n_fail++;
            $display("FAIL midscan_first: lat=%0d index=%0d need %0d/%0d",
                     lat, o_index, N - 4, ref_argmax(a));
        end
        @(negedge clk);
        i_valid = '0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b need 1", o_busy);
        end
        wait_valid(lat);
        n_checks++;
        if (lat != N - 1 || o_index !== 32'(ref_argmax(b))) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d index=%0d need %0d/%0d",
                     lat, o_index, N - 1, ref_argmax(b));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midscan;
        int e[N] = '{0, 0, 0, 0, 0, 0, 50, 0, 0, 0};
        bit seen = 0;
        start_scan(e);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({o_index, o_valid, o_busy} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid: index=%0d valid=%b busy=%b need 0/0/0",
                     o_index, o_valid, o_busy);
        end
`ifdef MAX_FINDER_MAXVAL_EN
        n_checks++;
        if (o_max !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_max: got %h need 0", o_max);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (o_valid || o_busy) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_abandon: activity seen=1 need 0");
        end
        run_and_check("after_reset", e);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_ties();
        test_signed();
        test_partial();
        test_random();
        test_back_to_back();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
